neuron_sequencer: RTL
=====================

// Module: neuron_sequencer
// PURPOSE
//  Per-tick controller directly upstream of the neuron block. On each tick it walks every
//  neuron: fetches its CSRAM row, loads the stored potential into the integrator, scans all
//  axons (integrate on spike AND synapse), writes the result back and forwards fired spikes
//  downstream over a valid/ready handshake. Sits between CSRAM/axon spike buffer and the
//  neuron block; spike output feeds the core's packet generator.
// PARAMETERS
//  NUM_NEURONS   256  neurons per core; neuron index width NW = $clog2(NUM_NEURONS)
//  NUM_AXONS     256  axons per core; axon index width AW = $clog2(NUM_AXONS)
//  NUM_WEIGHTS   4    axon types; instruction width TW = $clog2(NUM_WEIGHTS)
// PORTS
//  clk                     in   1        core clock, all state on rising edge
//  reset_n                 in   1        asynchronous, active-low reset
//  tick                    in   1        1-cycle pulse: start processing a time step
//  axon_spikes             in   NUM_AXONS    spike vector for current tick, stable while busy
//  axon_types              in   NUM_AXONS*TW type of axon a at bits [a*TW +: TW], static
//  csram_synapses          in   NUM_AXONS    synapse row of addressed neuron, 1 cycle after csram_re
//  csram_re                out  1        CSRAM read strobe
//  csram_addr              out  NW       CSRAM read/write address (current neuron)
//  potential_we            out  1        write neuron block write_potential to CSRAM at csram_addr
//  next_neuron             out  1        to neuron block: select stored potential
//  write_current_potential out  1        to neuron block: force weight to zero
//  integrator_reg_en       out  1        to neuron block: integrator register enable
//  neuron_instruction      out  TW       to neuron block: weight select
//  spike_in                in   1        neuron block spike_out
//  spike_valid             out  1        fired-neuron spike available
//  spike_ready             in   1        downstream accepts spike
//  spike_neuron_id         out  NW       index of firing neuron, valid with spike_valid
//  busy                    out  1        high from tick acceptance until done
//  done                    out  1        1-cycle pulse: tick fully processed
//  tick_overrun            out  1        1-cycle pulse: tick arrived while busy (tick dropped)
// BEHAVIOUR
//  Reset: state IDLE, counters 0; every output 0 (csram_addr, spike_neuron_id, instruction 0).
//  FSM (registered, Moore outputs):
//  IDLE: tick -> neuron=0, FETCH. busy=0.
//  FETCH: csram_re=1, csram_addr=neuron -> LOAD.
//  LOAD: register csram_synapses into syn_q; next_neuron=1, write_current_potential=1,
//   integrator_reg_en=1; axon=0 -> SCAN.
//  SCAN: one axon per cycle; neuron_instruction=axon_types[axon]; integrator_reg_en =
//   axon_spikes[axon] & syn_q[axon]. axon==NUM_AXONS-1 -> WRITE, else axon+1.
//  WRITE: potential_we=1, csram_addr=neuron; sample spike_in. spike_in=1 -> EMIT, else ADVANCE.
//  EMIT: spike_valid=1, spike_neuron_id=neuron, held stable until spike_valid&spike_ready;
//   transfer -> ADVANCE. No combinational ready->valid path.
//  ADVANCE: neuron==NUM_NEURONS-1 -> DONE, else neuron+1 -> FETCH (no wrap past last).
//  DONE: done=1 -> IDLE. busy=1 in every state except IDLE.
//  Latency: NUM_AXONS+4 cycles per non-firing neuron (FETCH..ADVANCE), +1+stall per spike;
//   tick to done = NUM_NEURONS*(NUM_AXONS+4)+spikes+stalls+1 cycles.
//  tick in any non-IDLE state (incl. DONE): ignored, tick_overrun pulses next cycle.
//  tick coincident with spike_ready stall: stall continues, overrun flagged.
//  reset_n low mid-operation: immediate return to IDLE; no write/spike/done emitted.
//  Counters are exact-width; no arithmetic beyond increment and compare.
// STRUCTURE
//  Package neuron_sequencer_pkg: state encoding localparams, NW/AW/TW width functions.
//  One sub-module: axon_scanner (axon counter, last-axon flag, type mux, spike&synapse gate).
// TESTING  (NUM_NEURONS=4, NUM_AXONS=4, NUM_WEIGHTS=4 unless noted)
//  1 Reset: reset_n low mid-SCAN -> all outputs 0 next edge, busy=0, no potential_we.
//  2 spikes=4'b1011, syn=4'b0011, types={3,2,1,0} -> en high on axons 0,1 only, instr 0 then 1;
//    done exactly 4*8+1=33 cycles after tick.
//  3 spike_in=1 on neuron 2, spike_ready low 5 cycles -> spike_valid held, id=2 stable, 1 transfer.
//  4 tick again at cycle 10 of a tick -> tick_overrun one pulse, run completes unchanged.
//  5 all neurons fire, spike_ready=1 -> ids 0,1,2,3 in order, done after 37 cycles.
//  6 NUM_NEURONS=1, NUM_AXONS=1: single FETCH/LOAD/SCAN/WRITE/ADVANCE/DONE, no counter wrap.

Source files
------------

// File: rtl/neuron_sequencer_pkg.sv
// Shared state encoding and index-width helpers for the neuron sequencer.
// Index widths never drop below one bit so single-entry cores still elaborate.
package neuron_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SCAN    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_EMIT    = 3'd5,
        ST_ADVANCE = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_sequencer_axon_scanner.sv
// Walks the axons of one neuron: axon counter, last-axon flag, per-axon type
// select and the spike-and-synapse gate that drives the integrator enable.
module axon_scanner
    import neuron_sequencer_pkg::*;
#(
    parameter int NUM_AXONS = 256,
    parameter int AW        = 8,
    parameter int TW        = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    step,
    input  logic [NUM_AXONS-1:0]    axon_spikes,
    input  logic [NUM_AXONS*TW-1:0] axon_types,
    input  logic [NUM_AXONS-1:0]    synapses,
    output logic                    last_axon,
    output logic [TW-1:0]           axon_type,
    output logic                    fire_gate
);

    logic [AW-1:0] axon_reg;
    logic [TW-1:0] type_arr [NUM_AXONS];

    generate
        for (genvar gi = 0; gi < NUM_AXONS; gi++) begin : g_type
            assign type_arr[gi] = axon_types[gi*TW +: TW];
        end
    endgenerate

    assign last_axon = (axon_reg == AW'(NUM_AXONS - 1));
    assign axon_type = type_arr[axon_reg];
    assign fire_gate = axon_spikes[axon_reg] & synapses[axon_reg];

    // Counter parks on the last axon; the next neuron's LOAD rewinds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axon_reg <= '0;
        end else if (load) begin
            axon_reg <= '0;
        end else if (step && !last_axon) begin
            axon_reg <= axon_reg + AW'(1);
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Per-tick controller: walks every neuron, integrates its active axons through
// the neuron block, writes the potential back and forwards fired spikes.
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int NUM_AXONS   = 256,
    parameter int NUM_WEIGHTS = 4,
    localparam int NW = idx_width(NUM_NEURONS),
    localparam int AW = idx_width(NUM_AXONS),
    localparam int TW = idx_width(NUM_WEIGHTS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic [NUM_AXONS-1:0]    axon_spikes,
    input  logic [NUM_AXONS*TW-1:0] axon_types,
    input  logic [NUM_AXONS-1:0]    csram_synapses,
    output logic                    csram_re,
    output logic [NW-1:0]           csram_addr,
    output logic                    potential_we,
    output logic                    next_neuron,
    output logic                    write_current_potential,
    output logic                    integrator_reg_en,
    output logic [TW-1:0]           neuron_instruction,
    input  logic                    spike_in,
    output logic                    spike_valid,
    input  logic                    spike_ready,
    output logic [NW-1:0]           spike_neuron_id,
    output logic                    busy,
    output logic                    done,
    output logic                    tick_overrun
);

    state_t                 state_reg, state_next;
    logic [NW-1:0]          neuron_reg;
    logic [NUM_AXONS-1:0]   syn_q_reg;
    logic                   overrun_reg;
    logic                   last_neuron;
    logic                   last_axon;
    logic                   scan_gate;
    logic [TW-1:0]          scan_type;

    assign last_neuron = (neuron_reg == NW'(NUM_NEURONS - 1));

    axon_scanner #(
        .NUM_AXONS (NUM_AXONS),
        .AW        (AW),
        .TW        (TW)
    ) u_scanner (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (state_reg == ST_LOAD),
        .step        (state_reg == ST_SCAN),
        .axon_spikes (axon_spikes),
        .axon_types  (axon_types),
        .synapses    (syn_q_reg),
        .last_axon   (last_axon),
        .axon_type   (scan_type),
        .fire_gate   (scan_gate)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neuron_reg  <= '0;
            syn_q_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= tick && (state_reg != ST_IDLE);
            if (state_reg == ST_IDLE && tick) begin
                neuron_reg <= '0;
            end else if (state_reg == ST_ADVANCE && !last_neuron) begin
                neuron_reg <= neuron_reg + NW'(1);
            end
            // CSRAM returns the row one cycle after the FETCH strobe.
            if (state_reg == ST_LOAD) begin
                syn_q_reg <= csram_synapses;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (tick) state_next = ST_FETCH;
            ST_FETCH:   state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_SCAN;
            ST_SCAN:    if (last_axon) state_next = ST_WRITE;
            ST_WRITE:   state_next = spike_in ? ST_EMIT : ST_ADVANCE;
            ST_EMIT:    if (spike_ready) state_next = ST_ADVANCE;
            ST_ADVANCE: state_next = last_neuron ? ST_DONE : ST_FETCH;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        csram_re                = 1'b0;
        csram_addr              = '0;
        potential_we            = 1'b0;
        next_neuron             = 1'b0;
        write_current_potential = 1'b0;
        integrator_reg_en       = 1'b0;
        neuron_instruction      = '0;
        spike_valid             = 1'b0;
        spike_neuron_id         = '0;
        busy                    = (state_reg != ST_IDLE);
        done                    = 1'b0;
        tick_overrun            = overrun_reg;
        case (state_reg)
            ST_FETCH: begin
                csram_re   = 1'b1;
                csram_addr = neuron_reg;
            end
            ST_LOAD: begin
                next_neuron             = 1'b1;
                write_current_potential = 1'b1;
                integrator_reg_en       = 1'b1;
            end
            ST_SCAN: begin
                neuron_instruction = scan_type;
                integrator_reg_en  = scan_gate;
            end
            ST_WRITE: begin
                potential_we = 1'b1;
                csram_addr   = neuron_reg;
            end
            ST_EMIT: begin
                spike_valid     = 1'b1;
                spike_neuron_id = neuron_reg;
            end
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
